// File: rtl/router_fifo_param.sv
// Packet-aware synchronous FIFO with tagged header words, level flags and a read-side packet tracker.
// Optional sticky overflow/underflow flag: define ROUTER_FIFO_OVF_ERR_EN.
module router_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    soft_reset,
    input  logic                    write_enb,
    input  logic                    read_enb,
    input  logic                    lfd_state,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    pkt_active,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = DATA_WIDTH - 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         remaining;
    logic [DATA_WIDTH:0]   rd_word;
    logic [CW-1:0]         len_load;
    logic                  wr_en, rd_en;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty        = (wr_ptr == rd_ptr);
    assign fill_level   = wr_ptr - rd_ptr;
    assign almost_full  = (fill_level >= AF_LVL);
    assign almost_empty = (fill_level <= AE_LVL);
    assign pkt_active   = (remaining != '0);

    assign wr_en    = write_enb && !full;
    assign rd_en    = read_enb && !empty;
    assign rd_word  = mem[rd_ptr[AW-1:0]];
    // Header length covers payload; the extra one accounts for the parity byte.
    assign len_load = {1'b0, rd_word[DATA_WIDTH-1:2]} + CW'(1);

    // Storage is never cleared; resetting the pointers makes old entries unreachable.
    always_ff @(posedge clock) begin
        if (wr_en && !soft_reset)
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            data_out  <= '0;
        end else if (soft_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            data_out  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) begin
                rd_ptr   <= rd_ptr + PW'(1);
                data_out <= rd_word[DATA_WIDTH-1:0];
                if (rd_word[DATA_WIDTH])
                    remaining <= len_load;
                else if (remaining != '0)
                    remaining <= remaining - CW'(1);
            end
        end
    end

`ifdef ROUTER_FIFO_OVF_ERR_EN
    // Sticky: records misuse but never blocks later traffic.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            ovf_err <= 1'b0;
        else if (soft_reset)
            ovf_err <= 1'b0;
        else if ((write_enb && full) || (read_enb && empty))
            ovf_err <= 1'b1;
    end
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo_param.sv
// Scoreboard bench for router_fifo_param: default 8x16 instance plus a 16x64 instance for thresholds and async reset.
module tb_router_fifo_param;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn, soft_reset, we, re, lfd;
    logic [7:0] din, dout;
    logic       full, empty, af, ae, pkt, ovf;
    logic [4:0] fill;

    logic        rst2_n, w2, r2, l2;
    logic [15:0] d2, dout2;
    logic        full2, empty2, af2, ae2, pkt2, ovf2;
    logic [6:0]  fill2;

    router_fifo_param dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(we), .read_enb(re), .lfd_state(lfd), .data_in(din),
        .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
        .fill_level(fill), .pkt_active(pkt), .data_out(dout), .ovf_err(ovf)
    );

    router_fifo_param #(.DATA_WIDTH(16), .DEPTH(64), .AF_THRESH(60), .AE_THRESH(4)) dut2 (
        .clock(clock), .resetn(rst2_n), .soft_reset(1'b0),
        .write_enb(w2), .read_enb(r2), .lfd_state(l2), .data_in(d2),
        .full(full2), .empty(empty2), .almost_full(af2), .almost_empty(ae2),
        .fill_level(fill2), .pkt_active(pkt2), .data_out(dout2), .ovf_err(ovf2)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] wq[$];
    logic [7:0] exp_q[$];
    logic       ovf_exp = 1'b0;
    logic       ovf_en;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic int ovf_want();
        return int'(ovf_exp && ovf_en);
    endfunction

    // Reference model updates from pre-edge occupancy, then drives one cycle.
    task automatic step(input bit w, input bit r, input bit l, input int d);
        bit mf, me;
        mf = (wq.size() == 16);
        me = (wq.size() == 0);
        if ((w && mf) || (r && me)) ovf_exp = 1'b1;
        if (r && !me) exp_q.push_back(wq.pop_front());
        if (w && !mf) wq.push_back(d[7:0]);
        we = w; re = r; lfd = l; din = d[7:0];
        @(posedge clock); #1;
        we = 1'b0; re = 1'b0; lfd = 1'b0;
    endtask

    // Monitor: every accepted read is checked against the scoreboard after the edge.
    always @(posedge clock) begin
        if (resetn && !soft_reset && re && !empty) begin
            #2;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_data actual=%0h expected=none", dout);
            end else begin
                chk("rd_data", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ROUTER_FIFO_OVF_ERR_EN
        ovf_en = 1'b1;
`else
        ovf_en = 1'b0;
`endif
        resetn = 1'b0; soft_reset = 1'b0; we = 1'b0; re = 1'b0; lfd = 1'b0; din = '0;
        rst2_n = 1'b0; w2 = 1'b0; r2 = 1'b0; l2 = 1'b0; d2 = '0;
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_ae", int'(ae), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(af), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_pkt", int'(pkt), 0);
        chk("rst_ovf", int'(ovf), 0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1; rst2_n = 1'b1;

        // Fill with a 14-byte packet plus parity
        step(1, 0, 1, 'h39);
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0, 'h10 + i);
            if (i == 11) chk("af_at13", int'(af), 0);
            if (i == 12) chk("af_at14", int'(af), 1);
        end
        step(1, 0, 0, 'h5A);
        chk("full_16", int'(full), 1);
        chk("fill_16", int'(fill), 16);
        chk("not_empty", int'(empty), 0);
        step(1, 0, 0, 'hAA);
        chk("drop_fill", int'(fill), 16);
        chk("ovf_set", int'(ovf), ovf_want());

        // Read+write while full: only the read happens
        step(1, 1, 0, 'hBB);
        chk("rw_full_fill", int'(fill), 15);
        chk("pkt_after_hdr", int'(pkt), 1);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0);
        chk("pkt_before_par", int'(pkt), 1);
        step(0, 1, 0, 0);
        chk("pkt_after_par", int'(pkt), 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_ae", int'(ae), 1);
        step(0, 1, 0, 0);
        chk("rd_empty_hold", int'(dout), 'h5A);
        chk("ovf_sticky", int'(ovf), ovf_want());

        // Steady-state streaming across pointer wrap
        for (int i = 0; i < 8; i++) step(1, 0, 0, 'h80 + i);
        chk("fill_8", int'(fill), 8);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 'h88 + i);
            chk("stream_fill", int'(fill), 8);
        end
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        chk("stream_empty", int'(empty), 1);

        // Short packet then soft reset with leftovers
        step(1, 0, 1, 'h04);
        step(1, 0, 0, 'h11);
        step(1, 0, 0, 'h22);
        step(1, 0, 0, 'h33);
        step(1, 0, 0, 'h44);
        step(1, 0, 0, 'h55);
        step(0, 1, 0, 0);
        chk("short_pkt_hdr", int'(pkt), 1);
        step(0, 1, 0, 0);
        chk("short_pkt_pay", int'(pkt), 1);
        step(0, 1, 0, 0);
        chk("short_pkt_par", int'(pkt), 0);
        chk("short_fill", int'(fill), 3);
        soft_reset = 1'b1; we = 1'b1; re = 1'b1; din = 8'hEE;
        @(posedge clock); #1;
        soft_reset = 1'b0; we = 1'b0; re = 1'b0;
        wq.delete();
        ovf_exp = 1'b0;
        chk("srst_fill", int'(fill), 0);
        chk("srst_empty", int'(empty), 1);
        chk("srst_pkt", int'(pkt), 0);
        chk("srst_dout", int'(dout), 0);
        chk("srst_ovf", int'(ovf), 0);
        step(1, 1, 0, 'h66);
        chk("rw_empty_dout", int'(dout), 0);
        chk("rw_empty_fill", int'(fill), 1);
        step(0, 1, 0, 0);
        chk("post_srst_empty", int'(empty), 1);

        // Wide instance: thresholds and asynchronous reset mid-read
        w2 = 1'b1; l2 = 1'b1; d2 = 16'h00FC;
        @(posedge clock); #1;
        l2 = 1'b0;
        for (int i = 1; i < 60; i++) begin
            d2 = 16'(i);
            @(posedge clock); #1;
            if (i == 58) begin
                chk("w_fill59", int'(fill2), 59);
                chk("w_af59", int'(af2), 0);
            end
            if (i == 59) begin
                chk("w_fill60", int'(fill2), 60);
                chk("w_af60", int'(af2), 1);
            end
        end
        w2 = 1'b0; r2 = 1'b1;
        @(posedge clock); #1;
        chk("w_first_rd", int'(dout2), 'h00FC);
        chk("w_pkt", int'(pkt2), 1);
        for (int j = 1; j <= 55; j++) begin
            @(posedge clock); #1;
            if (j == 54) chk("w_ae5", int'(ae2), 0);
            if (j == 55) chk("w_ae4", int'(ae2), 1);
        end
        chk("w_fill4", int'(fill2), 4);
        chk("w_pkt_mid", int'(pkt2), 1);
        #3 rst2_n = 1'b0;
        #1;
        chk("arst_fill", int'(fill2), 0);
        chk("arst_empty", int'(empty2), 1);
        chk("arst_ae", int'(ae2), 1);
        chk("arst_af", int'(af2), 0);
        chk("arst_full", int'(full2), 0);
        chk("arst_dout", int'(dout2), 0);
        chk("arst_pkt", int'(pkt2), 0);
        chk("arst_ovf", int'(ovf2), 0);
        r2 = 1'b0;
        @(posedge clock); #1 rst2_n = 1'b1;

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_fifo_param.md
Name: router_fifo_param

Overview:
- Parametrised, packet-aware synchronous FIFO. This is the next-generation storage element between the router's FSM/register front end and each of the three output channels.
- Width and depth are configurable. Every word carries a stored header tag (lfd).
- Adds almost-full/almost-empty flags, an occupancy count and a read-side packet tracker driven from the header's length field.

Parameters:
DATA_WIDTH, 8, payload word width in bits; min 3, since header = {len[DATA_WIDTH-1:2], addr[1:0]}
DEPTH, 16, number of entries; power of two, >= 4
AF_THRESH, DEPTH-2, almost_full asserts when fill_level >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when fill_level <= AE_THRESH

Ports:
clock  input  1  system clock; all state updates on rising edge
resetn  input  1  asynchronous, active-low reset
soft_reset  input  1  synchronous clear, active high (channel timeout)
write_enb  input  1  write request
read_enb  input  1  read request
lfd_state  input  1  current write word is a header; stored as tag bit
data_in  input  DATA_WIDTH  write data
full  output  1  fill_level == DEPTH
empty  output  1  fill_level == 0
almost_full  output  1  see AF_THRESH
almost_empty  output  1  see AE_THRESH
fill_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
pkt_active  output  1  read side is inside a packet (remaining count != 0)
data_out  output  DATA_WIDTH  registered read data
ovf_err  output  1  sticky overflow/underflow error (see Optional Feature)

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1). Bit DATA_WIDTH holds lfd_state captured with the word.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. Wrap uses the extra MSB.
  - full = (MSBs differ && low bits equal).
  - empty = (pointers equal).
  - fill_level = wr_ptr - rd_ptr, modulo width.
- All flags are combinational from the registered pointers.
- Write accepted on an edge with write_enb && !full. Read accepted on an edge with read_enb && !empty. Flags are sampled before the edge.
- Simultaneous read and write:
  - Neither full nor empty: both occur; fill_level unchanged.
  - When full: only the read occurs; the write is dropped.
  - When empty: only the write occurs; data_out is unchanged.
- Read latency: one cycle. data_out updates on the accepted-read edge to mem[rd_ptr] data bits, and holds otherwise. There is no tristate drive.
- Packet tracker (remaining counter, DATA_WIDTH-1 bits):
  - Read word with tag=1: counter loads word[DATA_WIDTH-1:2] + 1 (payload plus parity).
  - Read word with tag=0 while counter != 0: counter decrements.
  - pkt_active = (counter != 0).
  - A header with length 0 loads 1 (parity only).
  - A header read while counter != 0 (truncated previous packet) reloads the counter; no error.
- Priority order: resetn low > soft_reset > read/write.
- resetn low (asynchronous) clears:
  - pointers and counter to 0
  - data_out to 0
  - ovf_err to 0
  - Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0, fill_level=0, pkt_active=0.
- soft_reset high on an edge: same clears as resetn, applied synchronously. Writes and reads on that edge are ignored.
- Memory contents are not cleared on either reset. Stale tags are unreachable because the pointers reset.
- Reset mid-packet: the counter is cleared and any partial packet in the FIFO is discarded.

Optional Feature:
- Macro: ROUTER_FIFO_OVF_ERR_EN.
- Defined:
  - ovf_err sets on any edge with (write_enb && full) or (read_enb && empty).
  - It is sticky and cleared only by resetn or soft_reset.
  - It does not block subsequent operations.
- Undefined: ovf_err is tied to 0 and no error logic is synthesised.

Test Plan:
- Reset then idle, defaults (8/16) -> empty=1, almost_empty=1, full=0, fill_level=0, data_out=8'h00, pkt_active=0.
- Write header 8'h39 (len 14, addr 01) with lfd=1, then 14 payload bytes, then parity -> full=1, fill_level=16 after the 16th write. A 17th write with data 8'hAA is dropped; with ROUTER_FIFO_OVF_ERR_EN, ovf_err=1.
- Read back 16 words -> data_out matches write order, one cycle after each read edge.
  - pkt_active goes 1 after the header read and counter=15.
  - pkt_active drops to 0 after the parity read.
  - empty=1 and almost_empty=1 at the end.
- Fill to 8, then 20 cycles of simultaneous read+write with incrementing data -> fill_level stays 8; data order preserved across pointer wrap.
- Header 8'h04 (len 1) written and read with one payload and parity; then soft_reset while 3 words remain -> fill_level=0, empty=1, pkt_active=0, data_out=0 on the next cycle; old words never reappear.
- Instance with DATA_WIDTH=16, DEPTH=64, AF_THRESH=60, AE_THRESH=4: write 60 -> almost_full=1 at fill_level 60 and 0 at 59; read down to 4 -> almost_empty=1. Assert resetn low mid-read -> all outputs return to reset values immediately, without waiting for a clock edge.
